wrr_arbiter_param: RTL and testbench
====================================

Name: wrr_arbiter_param

Overview:
Parametrised weighted round-robin arbiter for the QoS PCIe path. It pops NUM_CH class FIFOs according to per-channel weights programmed at runtime, and decodes the class field of incoming words into per-FIFO push strobes. Compared with the fixed 4-channel 4/3/2/1 arbiter, it adds:
- programmable weights;
- work-conserving round reload;
- a strict-priority mode;
- per-FIFO backpressure mode;
- class-error and round-done status.

Parameters:
NUM_CH, 4, number of class FIFOs/channels (2..16)
WEIGHT_W, 3, bits per channel weight; max weight 2**WEIGHT_W-1
DATA_W, 12, width of incoming word
CLASS_LSB, 8, LSB of class field inside data_in
CLASS_W, 2, width of class field
GLOBAL_STALL, 1, 1: any almost_full halts all pops/pushes; 0: only the affected channel is blocked

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
prio_mode  in  1  0 = weighted round-robin, 1 = strict priority (lowest index wins)
weights  in  NUM_CH*WEIGHT_W  weight of ch i at [i*WEIGHT_W +: WEIGHT_W]
empty_fifo  in  NUM_CH  source FIFO empty flags
almost_full_fifo  in  NUM_CH  destination FIFO almost-full flags
data_in  in  DATA_W  incoming word
data_valid  in  1  data_in is valid this cycle
pop  out  NUM_CH  one-hot-or-zero pop strobe, combinational
push  out  NUM_CH  one-hot-or-zero push strobe, combinational
grant_id  out  clog2(NUM_CH)  index of popped channel, 0 when grant_valid=0
grant_valid  out  1  |pop
round_done  out  1  registered 1-cycle pulse when a WRR round reloads
class_err  out  1  registered 1-cycle pulse: valid word with class >= NUM_CH

Behaviour:
- State: credit[i] (WEIGHT_W bits) = grants given to ch i in the current round; round_done and class_err regs.
- Reset (sync, high): all credit=0, round_done=0, class_err=0. pop=0 and push=0 while reset=1, regardless of other inputs.
- Stall (stall_i):
  - GLOBAL_STALL=1: stall_i = |almost_full_fifo for every i.
  - GLOBAL_STALL=0: stall_i = almost_full_fifo[i].
- Eligibility:
  - Candidate: cand_i = !empty_fifo[i] & !stall_i & weight_i!=0.
  - Eligible: elig_i = cand_i & credit[i] < weight_i.
- WRR mode (prio_mode=0), all in the same cycle:
  - If any elig_i: pop the lowest-index eligible channel; its credit increments at the clock edge; other credits hold.
  - Else if any cand_i (all candidates exhausted): reload. Pop the lowest-index cand_i; next-cycle credits = 0 except the granted channel = 1; round_done=1 next cycle. No bubble cycle.
  - Else (no candidate): pop=0, credits hold, round_done=0.
- Strict mode (prio_mode=1): pop the lowest-index cand_i (weight 0 still excludes); credits hold; round_done=0. On return to WRR, the round resumes from the held credits.
- Weight change mid-round: takes effect immediately. credit >= new weight makes the channel ineligible. Credit never exceeds 2**WEIGHT_W-1; no wrap.
- Push decode:
  - cls = data_in[CLASS_LSB +: CLASS_W].
  - If data_valid & cls<NUM_CH & !stall_cls: push[cls]=1, else 0.
  - If data_valid & cls>=NUM_CH: push=0 and class_err=1 next cycle.
  - A push blocked by stall is dropped; upstream must honour almost_full.
- Independence: pop and push to the same channel in one cycle are allowed.
- Latency: pop/push are combinational (0 cycles); status pulses have 1 cycle latency.
- Reset mid-round: credits clear at that edge; the next round starts fresh.

Test Plan:
1. NUM_CH=4, weights=4,3,2,1, all FIFOs non-empty, no stall, prio_mode=0 -> grant_id sequence 0,0,0,0,1,1,1,2,2,3,0,… The 11th grant (ch0) is a reload; round_done pulses the cycle after it; one grant per cycle, no bubble.
2. Same setup with ch1 empty throughout -> sequence 0,0,0,0,2,2,3 then reload to 0.
3. After 2 grants on ch0, almost_full_fifo=4'b0100 with GLOBAL_STALL=1 for 3 cycles -> pop=0 and push=0 for those 3 cycles, credits hold; the next grant after release is ch0 (its 3rd).
4. prio_mode=1, empty_fifo=4'b1100 -> pop=4'b0001 every cycle, credits unchanged. Switch to WRR with ch0 credit=4 -> pop=4'b0010.
5. data_valid=1 with data_in[9:8] = 0,1,2,3 on consecutive cycles -> push = 0001, 0010, 0100, 1000. With NUM_CH=3, class 3 -> push=0 and class_err pulses one cycle later.
6. Reset asserted mid-round (ch1 credit=2) for 1 cycle -> pop=0 that cycle; afterwards the grant sequence restarts 0,0,0,0,1,1,1; weight of ch3 set to 0 -> ch3 is never popped even when it is the only non-empty FIFO.

Source files
------------

// File: rtl/wrr_arbiter_param.sv
// Weighted round-robin arbiter for the QoS PCIe path.
// Pops one of NUM_CH class FIFOs per cycle according to runtime weights,
// with an optional strict-priority mode. It also decodes the class field of
// incoming words into per-FIFO push strobes.
module wrr_arbiter_param #(
    parameter int NUM_CH       = 4,
    parameter int WEIGHT_W     = 3,
    parameter int DATA_W       = 12,
    parameter int CLASS_LSB    = 8,
    parameter int CLASS_W      = 2,
    parameter int GLOBAL_STALL = 1,
    localparam int GID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       prio_mode,
    input  logic [NUM_CH*WEIGHT_W-1:0] weights,
    input  logic [NUM_CH-1:0]          empty_fifo,
    input  logic [NUM_CH-1:0]          almost_full_fifo,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       data_valid,
    output logic [NUM_CH-1:0]          pop,
    output logic [NUM_CH-1:0]          push,
    output logic [GID_W-1:0]           grant_id,
    output logic                       grant_valid,
    output logic                       round_done,
    output logic                       class_err
);

    logic [NUM_CH-1:0][WEIGHT_W-1:0] weight;
    logic [NUM_CH-1:0][WEIGHT_W-1:0] credit;
    logic [NUM_CH-1:0][WEIGHT_W-1:0] credit_next;
    logic [NUM_CH-1:0]               stall;
    logic [NUM_CH-1:0]               cand;
    logic [NUM_CH-1:0]               elig;
    logic [GID_W-1:0]                cand_idx;
    logic [GID_W-1:0]                elig_idx;
    logic                            reload;
    logic [31:0]                     cls_ext;
    logic                            class_bad;
    logic                            unused_data;

    assign weight = weights;

    // Only the class field of data_in steers the design; the payload bits pass
    // through the FIFOs elsewhere and are folded here so they count as read.
    assign unused_data = ^data_in;

    // Stall and eligibility: a channel is a candidate when it has data, is not
    // blocked and has a non-zero weight; it is eligible while credit remains.
    always_comb begin
        stall = (GLOBAL_STALL != 0) ? {NUM_CH{|almost_full_fifo}} : almost_full_fifo;
        cand  = '0;
        elig  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = !empty_fifo[i] && !stall[i] && (weight[i] != '0);
            elig[i] = cand[i] && (credit[i] < weight[i]);
        end
    end

    // Lowest-index selection among candidates and among eligible channels.
    always_comb begin
        cand_idx = '0;
        elig_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) cand_idx = GID_W'(i);
            if (elig[i]) elig_idx = GID_W'(i);
        end
    end

    // Grant decision and next credits: a normal grant when someone is eligible,
    // otherwise a reload that grants immediately so no bubble cycle appears.
    always_comb begin
        pop         = '0;
        grant_id    = '0;
        credit_next = credit;
        reload      = 1'b0;
        if (!reset) begin
            if (prio_mode) begin
                if (|cand) begin
                    pop[cand_idx] = 1'b1;
                    grant_id      = cand_idx;
                end
            end else if (|elig) begin
                pop[elig_idx]         = 1'b1;
                grant_id              = elig_idx;
                credit_next[elig_idx] = credit[elig_idx] + 1'b1;
            end else if (|cand) begin
                pop[cand_idx]         = 1'b1;
                grant_id              = cand_idx;
                credit_next           = '0;
                credit_next[cand_idx] = WEIGHT_W'(1);
                reload                = 1'b1;
            end
        end
    end

    assign grant_valid = |pop;

    // Push decode: the class field selects the destination FIFO unless that
    // FIFO is stalled; out-of-range classes raise a class error instead.
    always_comb begin
        cls_ext   = 32'(data_in[CLASS_LSB +: CLASS_W]);
        class_bad = data_valid && (cls_ext >= NUM_CH);
        push      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            push[i] = !reset && data_valid && (cls_ext == i) && !stall[i];
        end
    end

    // Credit state and the two one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit     <= '0;
            round_done <= 1'b0;
            class_err  <= 1'b0;
        end else begin
            credit     <= credit_next;
            round_done <= reload;
            class_err  <= class_bad;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter_param.sv
// Directed testbench for wrr_arbiter_param: a 4-channel instance for the
// arbitration scenarios and a 3-channel instance for the class-error path.
module tb_wrr_arbiter_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        prio_mode;
    logic [11:0] weights;
    logic [3:0]  empty_fifo;
    logic [3:0]  almost_full_fifo;
    logic [11:0] data_in;
    logic        data_valid;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic        round_done;
    logic        class_err;

    logic [8:0]  weights3;
    logic [2:0]  empty3;
    logic [2:0]  af3;
    logic [2:0]  pop3;
    logic [2:0]  push3;
    logic [1:0]  grant_id3;
    logic        grant_valid3;
    logic        round_done3;
    logic        class_err3;

    int cnt_compared   = 0;
    int cnt_mismatched = 0;

    always #5 clk = ~clk;

    wrr_arbiter_param #(.NUM_CH(4), .GLOBAL_STALL(1)) u_dut (
        .clk(clk), .reset(reset), .prio_mode(prio_mode), .weights(weights),
        .empty_fifo(empty_fifo), .almost_full_fifo(almost_full_fifo),
        .data_in(data_in), .data_valid(data_valid), .pop(pop), .push(push),
        .grant_id(grant_id), .grant_valid(grant_valid),
        .round_done(round_done), .class_err(class_err)
    );

    wrr_arbiter_param #(.NUM_CH(3), .GLOBAL_STALL(1)) u_dut3 (
        .clk(clk), .reset(reset), .prio_mode(prio_mode), .weights(weights3),
        .empty_fifo(empty3), .almost_full_fifo(af3),
        .data_in(data_in), .data_valid(data_valid), .pop(pop3), .push(push3),
        .grant_id(grant_id3), .grant_valid(grant_valid3),
        .round_done(round_done3), .class_err(class_err3)
    );

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cnt_compared++;
        if (got !== exp) begin
            cnt_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then settles for sampling.
    task automatic applyStimulus(input logic rst, input logic pm, input logic [3:0] emp,
                                 input logic [3:0] af, input logic dv, input logic [11:0] din);
        @(negedge clk);
        reset            = rst;
        prio_mode        = pm;
        empty_fifo       = emp;
        almost_full_fifo = af;
        data_valid       = dv;
        data_in          = din;
        #1;
    endtask

    // Expects a single grant to channel id this cycle.
    task automatic expectGrant(input string tag, input int id);
        checkOutput({tag, " pop"}, 32'(pop), 32'(1) << id);
        checkOutput({tag, " grant_id"}, 32'(grant_id), 32'(id));
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, " pop"}, 32'(pop), 32'h0);
        checkOutput({tag, " grant_valid"}, 32'(grant_valid), 32'h0);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 12'h000);
        expectIdle({tag, " reset"});
        checkOutput({tag, " reset push"}, 32'(push), 32'h0);
    endtask

    int seq1 [11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 0};
    int seq1b [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 3};
    int seq2 [8]  = '{0, 0, 0, 0, 2, 2, 3, 0};

    initial begin
        weights  = {3'd1, 3'd2, 3'd3, 3'd4};
        weights3 = {3'd1, 3'd1, 3'd1};
        empty3   = 3'b111;
        af3      = 3'b000;

        // Scenario 1: full round, reload without bubble, round_done pulse.
        doReset("s1");
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s1 g%0d", k), seq1[k]);
            checkOutput($sformatf("s1 rd%0d", k), 32'(round_done), 32'h0);
        end
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s1 r2g%0d", k), seq1b[k]);
            checkOutput($sformatf("s1 r2rd%0d", k), 32'(round_done), (k == 0) ? 32'h1 : 32'h0);
        end

        // Scenario 2: ch1 empty throughout.
        doReset("s2");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s2 g%0d", k), seq2[k]);
        end
        applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 12'h000);
        checkOutput("s2 round_done", 32'(round_done), 32'h1);
        expectGrant("s2 post", 0);

        // Scenario 3: global stall freezes pops, pushes and credits.
        doReset("s3");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s3 g%0d", k), 0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0100, 1'b1, 12'h000);
            expectIdle($sformatf("s3 stall%0d", k));
            checkOutput($sformatf("s3 stall%0d push", k), 32'(push), 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
        expectGrant("s3 resume0", 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
        expectGrant("s3 resume1", 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
        expectGrant("s3 resume2", 1);

        // Scenario 4: strict priority holds credits; WRR resumes from them.
        doReset("s4");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s4 w%0d", k), 0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 12'h000);
            checkOutput($sformatf("s4 prio%0d pop", k), 32'(pop), 32'h1);
            checkOutput($sformatf("s4 prio%0d rd", k), 32'(round_done), 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s4 back%0d", k), 0);
        end
        applyStimulus(1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 12'h000);
        checkOutput("s4 prio ch0 full pop", 32'(pop), 32'h1);
        applyStimulus(1'b0, 1'b0, 4'b1100, 4'b0000, 1'b0, 12'h000);
        checkOutput("s4 wrr ch0 exhausted pop", 32'(pop), 32'h2);

        // Scenario 5: class decode and class error on the 3-channel instance.
        doReset("s5");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 12'(c) << 8);
            checkOutput($sformatf("s5 push c%0d", c), 32'(push), 32'(1) << c);
            checkOutput($sformatf("s5 class_err c%0d", c), 32'(class_err), 32'h0);
            if (c == 3) begin
                checkOutput("s5 push3 c3", 32'(push3), 32'h0);
                checkOutput("s5 class_err3 before", 32'(class_err3), 32'h0);
            end
        end
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 12'h000);
        checkOutput("s5 class_err3 pulse", 32'(class_err3), 32'h1);
        checkOutput("s5 push idle", 32'(push), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 12'h000);
        checkOutput("s5 class_err3 clear", 32'(class_err3), 32'h0);

        // Scenario 6: reset mid-round, then a zero-weight channel.
        doReset("s6");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s6 pre%0d", k), (k < 4) ? 0 : 1);
        end
        doReset("s6 mid");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000);
            expectGrant($sformatf("s6 g%0d", k), seq1[k]);
        end
        weights = {3'd0, 3'd2, 3'd3, 3'd4};
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0, 12'h000);
            expectIdle($sformatf("s6 w0 idle%0d", k));
            checkOutput($sformatf("s6 w0 rd%0d", k), 32'(round_done), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_compared, cnt_mismatched);
        $finish;
    end

endmodule
